// File: rtl/axil_cmd_master_if.sv
// rtl/axil_cmd_master_if.sv - command/response and AXI4-Lite master signal bundle
interface axil_cmd_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [DATA_W/8-1:0]   cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic [ADDR_W-1:0]     m_axi_awaddr;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [2:0]            m_axi_awprot;
  logic [DATA_W-1:0]     m_axi_wdata;
  logic [DATA_W/8-1:0]   m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_W-1:0]     m_axi_araddr;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [2:0]            m_axi_arprot;
  logic [DATA_W-1:0]     m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awvalid, m_axi_awprot,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, m_axi_arprot,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awvalid, m_axi_awprot,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid, m_axi_arprot,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// rtl/axil_cmd_master.sv - single-outstanding command to AXI4-Lite master with response timeout
module axil_cmd_master #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      Clk,
  input  logic                      Rst,
  axil_cmd_master_if.master         bus,
  output logic                      busy
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                aw_done_q, w_done_q;
  logic                drain_b_q, drain_r_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic                rsp_timeout_q;

  logic cmd_ready_w, cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs, expire;

  // Handshakes derived from registered state only, so nothing here loops through the FSM logic
  assign cmd_ready_w = (state_q == IDLE) && !drain_b_q && !drain_r_q && !Rst;
  assign cmd_hs      = bus.cmd_valid && cmd_ready_w;
  assign aw_hs       = (state_q == WADDR) && !aw_done_q && bus.m_axi_awready;
  assign w_hs        = (state_q == WADDR) && !w_done_q && bus.m_axi_wready;
  assign ar_hs       = (state_q == RADDR) && bus.m_axi_arready;
  assign b_hs        = bus.m_axi_bvalid && ((state_q == WRESP) || drain_b_q);
  assign r_hs        = bus.m_axi_rvalid && ((state_q == RRESP) || drain_r_q);
  assign rsp_hs      = (state_q == RSP) && bus.rsp_ready;
  assign expire      = (cnt_q == CNT_LAST);

  assign bus.m_axi_awaddr = addr_q;
  assign bus.m_axi_araddr = addr_q;
  assign bus.m_axi_wdata  = wdata_q;
  assign bus.m_axi_wstrb  = wstrb_q;
  assign bus.m_axi_awprot = 3'b000;
  assign bus.m_axi_arprot = 3'b000;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_resp     = rsp_resp_q;
  assign bus.rsp_timeout  = rsp_timeout_q;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and channel valid/ready outputs; drain flags keep the late-response ready high everywhere
  always_comb begin
    state_d           = state_q;
    bus.cmd_ready     = cmd_ready_w;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_bready  = drain_b_q;
    bus.m_axi_rready  = drain_r_q;
    bus.rsp_valid     = 1'b0;
    busy              = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (cmd_hs) state_d = bus.cmd_write ? WADDR : RADDR;
      end
      WADDR: begin
        bus.m_axi_awvalid = !aw_done_q;
        bus.m_axi_wvalid  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      end
      WRESP: begin
        bus.m_axi_bready = 1'b1;
        if (b_hs || expire) state_d = RSP;
      end
      RADDR: begin
        bus.m_axi_arvalid = 1'b1;
        if (ar_hs) state_d = RRESP;
      end
      RRESP: begin
        bus.m_axi_rready = 1'b1;
        if (r_hs || expire) state_d = RSP;
      end
      RSP: begin
        bus.rsp_valid = 1'b1;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command capture, AW/W progress, wait counter, response capture and drain bookkeeping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      drain_b_q     <= 1'b0;
      drain_r_q     <= 1'b0;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q    <= bus.cmd_addr;
        wdata_q   <= bus.cmd_wdata;
        wstrb_q   <= bus.cmd_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end

      // Counter runs only while waiting for a response, so it is zero on every entry
      if (((state_q == WRESP) && !b_hs) || ((state_q == RRESP) && !r_hs))
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;

      if (state_q == WRESP) begin
        if (b_hs) begin
          rsp_rdata_q   <= '0;
          rsp_resp_q    <= bus.m_axi_bresp;
          rsp_timeout_q <= 1'b0;
        end else if (expire) begin
          rsp_rdata_q   <= '0;
          rsp_resp_q    <= 2'b10;
          rsp_timeout_q <= 1'b1;
          drain_b_q     <= 1'b1;
        end
      end else if (drain_b_q && bus.m_axi_bvalid) begin
        drain_b_q <= 1'b0;
      end

      if (state_q == RRESP) begin
        if (r_hs) begin
          rsp_rdata_q   <= bus.m_axi_rdata;
          rsp_resp_q    <= bus.m_axi_rresp;
          rsp_timeout_q <= 1'b0;
        end else if (expire) begin
          rsp_rdata_q   <= '0;
          rsp_resp_q    <= 2'b10;
          rsp_timeout_q <= 1'b1;
          drain_r_q     <= 1'b1;
        end
      end else if (drain_r_q && bus.m_axi_rvalid) begin
        drain_r_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb/tb_axil_cmd_master.sv - self-checking bench for axil_cmd_master
module tb_axil_cmd_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  axil_cmd_master_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axil_cmd_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .Clk  (clk),
    .Rst  (rst),
    .bus  (bus.master),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid     = 1'b0;
    bus.cmd_write     = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_wdata     = '0;
    bus.cmd_wstrb     = '0;
    bus.rsp_ready     = 1'b0;
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b0;
    bus.m_axi_bresp   = 2'b00;
    bus.m_axi_bvalid  = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rvalid  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid_ready"}, 64'({bus.cmd_ready, bus.rsp_valid, busy, bus.m_axi_awvalid,
        bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready, bus.m_axi_rready}), 64'd0);
    chk({tag, "_rsp"}, 64'({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout}), 64'd0);
    chk({tag, "_addr"}, {bus.m_axi_awaddr, bus.m_axi_araddr}, 64'd0);
    chk({tag, "_wdata"}, 64'({bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_awprot, bus.m_axi_arprot}), 64'd0);
  endtask

  // One command end to end: slave delays count cycles of valid (AW/W/AR) or cycles since the
  // first ready (B/R); the response wait expires after TMO ready cycles without a handshake.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int aw_d, input int w_d, input int ar_d,
                         input int rsp_d, input logic [1:0] resp, input logic [31:0] rdata,
                         input int hold);
    bit          tmo;
    int          lat;
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    int t = 0, c_cmd = -1, t_first = -1, t_rsp_hs = -1, t_ready = -1, t_start = -1, t_hs = -1;
    int aw_n = 0, w_n = 0, ar_n = 0, resp_n = 0, aw_seen = 0, w_seen = 0, ar_seen = 0;
    bit cmd_sent = 0, given = 0, done = 0, drop = 0, data_bad = 0, unstable = 0, extra = 0;
    bit busy_rsp = 0, busy_idle = 1;
    logic rdy, vld;
    logic [31:0] o_rdata;
    logic [1:0]  o_resp;
    logic        o_tmo;

    tmo     = (rsp_d > TMO - 1);
    lat     = 3 + (wr ? ((aw_d > w_d) ? aw_d : w_d) : ar_d) + (tmo ? TMO - 1 : rsp_d);
    e_resp  = tmo ? 2'b10 : resp;
    e_rdata = (wr || tmo) ? 32'd0 : rdata;
    o_rdata = 'x;
    o_resp  = 'x;
    o_tmo   = 'x;

    while (!done && t < 300) begin
      @(negedge clk);
      if (!cmd_sent) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_wstrb = wstrb;
        if (bus.cmd_ready) begin cmd_sent = 1; c_cmd = t; end
      end else begin
        bus.cmd_valid = 1'b0;
      end

      if (bus.m_axi_awvalid) begin
        if (bus.m_axi_awaddr !== addr) data_bad = 1;
        bus.m_axi_awready = (aw_seen >= aw_d);
        if (aw_seen >= aw_d) aw_n++;
        aw_seen++;
      end else begin
        bus.m_axi_awready = 1'b0;
        if (aw_seen > 0 && aw_n == 0) drop = 1;
      end

      if (bus.m_axi_wvalid) begin
        if (bus.m_axi_wdata !== wdata || bus.m_axi_wstrb !== wstrb) data_bad = 1;
        bus.m_axi_wready = (w_seen >= w_d);
        if (w_seen >= w_d) w_n++;
        w_seen++;
      end else begin
        bus.m_axi_wready = 1'b0;
        if (w_seen > 0 && w_n == 0) drop = 1;
      end

      if (bus.m_axi_arvalid) begin
        if (bus.m_axi_araddr !== addr) data_bad = 1;
        bus.m_axi_arready = (ar_seen >= ar_d);
        if (ar_seen >= ar_d) ar_n++;
        ar_seen++;
      end else begin
        bus.m_axi_arready = 1'b0;
        if (ar_seen > 0 && ar_n == 0) drop = 1;
      end

      rdy = wr ? bus.m_axi_bready : bus.m_axi_rready;
      if (rdy && t_start < 0) t_start = t;
      vld = (t_start >= 0) && !given && ((t - t_start) >= rsp_d);
      bus.m_axi_bvalid = wr & vld;
      bus.m_axi_bresp  = resp;
      bus.m_axi_rvalid = !wr & vld;
      bus.m_axi_rdata  = rdata;
      bus.m_axi_rresp  = resp;
      if (vld && rdy) begin given = 1; resp_n++; t_hs = t; end

      if (bus.rsp_valid) begin
        if (t_rsp_hs >= 0) extra = 1;
        if (t_first < 0) begin
          t_first  = t;
          o_rdata  = bus.rsp_rdata;
          o_resp   = bus.rsp_resp;
          o_tmo    = bus.rsp_timeout;
          busy_rsp = busy;
        end else if ({bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout} !== {o_rdata, o_resp, o_tmo}) begin
          unstable = 1;
        end
        if (t_rsp_hs < 0 && (t - t_first) >= hold) begin
          bus.rsp_ready = 1'b1;
          t_rsp_hs = t;
        end else begin
          bus.rsp_ready = 1'b0;
        end
      end else begin
        bus.rsp_ready = 1'b0;
      end

      if (t_rsp_hs >= 0 && t > t_rsp_hs && bus.cmd_ready) begin
        t_ready   = t;
        busy_idle = busy;
        done      = 1;
      end
      t++;
    end
    idle_inputs();

    chk("txn_completed", 64'(done), 64'd1);
    if (wr) begin
      chk("aw_handshakes", 64'(aw_n), 64'd1);
      chk("w_handshakes", 64'(w_n), 64'd1);
      chk("ar_on_write", 64'(ar_n), 64'd0);
    end else begin
      chk("ar_handshakes", 64'(ar_n), 64'd1);
      chk("aw_w_on_read", 64'(aw_n + w_n), 64'd0);
    end
    chk("resp_channel_handshakes", 64'(resp_n), 64'd1);
    chk("rsp_latency", 64'(t_first - c_cmd), 64'(lat));
    chk("rsp_rdata", 64'(o_rdata), 64'(e_rdata));
    chk("rsp_resp", 64'(o_resp), 64'(e_resp));
    chk("rsp_timeout", 64'(o_tmo), 64'(tmo));
    chk("rsp_stable", 64'(unstable), 64'd0);
    chk("single_rsp", 64'(extra), 64'd0);
    chk("valid_held", 64'(drop), 64'd0);
    chk("addr_data_stable", 64'(data_bad), 64'd0);
    chk("cmd_ready_latency", 64'(t_ready - ((t_rsp_hs > t_hs) ? t_rsp_hs : t_hs)), 64'd1);
    chk("busy_in_rsp", 64'(busy_rsp), 64'd1);
    chk("busy_idle", 64'(busy_idle), 64'd0);
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", 64'(bus.cmd_ready), 64'd1);
    chk("busy_after_reset", 64'(busy), 64'd0);

    // Basic write, everything ready: rsp_valid three cycles after the command
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    // W held five cycles after AW
    run_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h5, 0, 5, 0, 1, 2'b00, 32'h0, 1);
    // AW late relative to W
    run_txn(1'b1, 32'h0000_0024, 32'h0BAD_CAFE, 4'h3, 4, 1, 0, 2, 2'b01, 32'h0, 0);
    // Read with slow data and a slow consumer
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 3, 2'b00, 32'h1234_5678, 4);
    // Read timeout, late R discarded
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 1, 0, 1, 12, 2'b00, 32'hA5A5_5A5A, 2);
    // Response exactly on the expiry cycle is normal; one later is a timeout
    run_txn(1'b1, 32'h0000_0030, 32'h1111_2222, 4'hC, 0, 0, 0, TMO - 1, 2'b01, 32'h0, 0);
    run_txn(1'b1, 32'h0000_0034, 32'h3333_4444, 4'h1, 0, 0, 0, TMO, 2'b00, 32'h0, 0);
    run_txn(1'b0, 32'h0000_0038, 32'h0, 4'h0, 0, 0, 2, TMO - 1, 2'b11, 32'h7777_8888, 0);
    // SLVERR on write
    run_txn(1'b1, 32'h0000_0040, 32'h5555_6666, 4'hF, 0, 0, 0, 1, 2'b10, 32'h0, 0);

    // Reset while waiting in WRESP abandons the write
    @(negedge clk);
    bus.cmd_valid     = 1'b1;
    bus.cmd_write     = 1'b1;
    bus.cmd_addr      = 32'h0000_0050;
    bus.cmd_wdata     = 32'h9999_AAAA;
    bus.cmd_wstrb     = 4'hF;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    n = 0;
    while (!bus.m_axi_bready && n < 20) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n++;
    end
    chk("reached_wresp", 64'(bus.m_axi_bready), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("cmd_ready_after_mid_reset", 64'(bus.cmd_ready), 64'd1);
    chk("busy_after_mid_reset", 64'(busy), 64'd0);
    run_txn(1'b0, 32'h0000_0060, 32'h0, 4'h0, 1, 0, 1, 2, 2'b00, 32'hFEED_0001, 1);

    // Random transactions
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_W, 32, AXI data width; only 32 supported.
- ADDR_W, 32, AXI address width.
- TIMEOUT, 1024, response-wait cycle limit; minimum 2.

REQ-002 Ports (name, direction, width, meaning):
- Clk, in, 1, the single clock; all logic rising-edge.
- Rst, in, 1, synchronous active-high reset.
- cmd_valid / cmd_ready, in / out, 1 / 1, command handshake.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_W, transaction address.
- cmd_wdata / cmd_wstrb, in, DATA_W / DATA_W/8, write data and byte strobes; ignored for reads.
- rsp_valid / rsp_ready, out / in, 1 / 1, response handshake.
- rsp_rdata, out, DATA_W, read data; 0 for writes and timeouts.
- rsp_resp, out, 2, AXI response code returned by the slave.
- rsp_timeout, out, 1, 1 = transaction aborted by timeout.
- busy, out, 1, high in any state other than IDLE.
- m_axi_awaddr / awvalid / awready / awprot, out / out / in / out, ADDR_W / 1 / 1 / 3, write-address channel.
- m_axi_wdata / wstrb / wvalid / wready, out / out / out / in, DATA_W / DATA_W/8 / 1 / 1, write-data channel.
- m_axi_bresp / bvalid / bready, in / in / out, 2 / 1 / 1, write-response channel.
- m_axi_araddr / arvalid / arready / arprot, out / out / in / out, ADDR_W / 1 / 1 / 3, read-address channel.
- m_axi_rdata / rresp / rvalid / rready, in / in / in / out, DATA_W / 2 / 1 / 1, read-data channel.

Function
REQ-003 FSM states: IDLE, WADDR, WRESP, RADDR, RRESP, RSP. One transaction outstanding at most.
REQ-004 cmd_ready is high only in IDLE with no drain pending (REQ-011), and is 0 while Rst is high.
REQ-005 Command capture:
- On cmd_valid & cmd_ready, register addr, wdata and wstrb.
- Next cycle: write → WADDR with awvalid = wvalid = 1; read → RADDR with arvalid = 1.
REQ-006 WADDR:
- awvalid drops the cycle after the AW handshake; wvalid drops the cycle after the W handshake; the two are tracked independently.
- Handshakes may occur in the same cycle or in either order.
- Go to WRESP once both have completed.
REQ-007 Valid stability: awvalid, wvalid and arvalid, once asserted, never deassert before their handshake; address, data and strobe stay stable until then. No timeout applies in WADDR or RADDR.
REQ-008 RADDR: arvalid held until arready; then go to RRESP.
REQ-009 Response capture:
- WRESP: bready = 1; on bvalid capture bresp, set rsp_rdata = 0, go to RSP.
- RRESP: rready = 1; on rvalid capture rdata and rresp, go to RSP.
REQ-010 Timeout:
- A counter clears on entry to WRESP or RRESP and increments each cycle without the response handshake.
- When the counter reaches TIMEOUT-1 with no handshake, go to RSP with rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0.
- A handshake in the same cycle as expiry wins, with a normal response.
REQ-011 Drain after timeout:
- Set drain_b (write) or drain_r (read).
- While a drain flag is set, bready or rready respectively stays high in every state and cmd_ready stays low.
- The first late B or R handshake is discarded and clears the flag.
- A drain may remain pending indefinitely.
REQ-012 RSP: rsp_valid = 1 with all rsp_* held stable until rsp_ready; on handshake go to IDLE. Latency from rsp_ready to the next cmd_ready is one cycle.
REQ-013 Constant and derived outputs: awprot = arprot = 3'b000. rsp_rdata, rsp_resp and rsp_timeout are registered and update only on entry to RSP.
REQ-014 Minimum write latency: cmd handshake at cycle 0; awvalid/wvalid at cycle 1; B handshake at cycle 2 earliest; rsp_valid at cycle 3.

Reset
REQ-015 While Rst is high, at the next edge:
- State = IDLE; counter and drain flags cleared.
- All valid/ready outputs = 0, busy = 0, all data outputs = 0.
REQ-016 Reset asserted mid-transaction abandons it with no response. cmd_ready rises the first cycle after Rst deasserts.

Verification
REQ-017 Write to 0x0000_0010, data 0xDEAD_BEEF, strb 0xF, slave always ready, bresp OKAY → AW and W in the same cycle; rsp_valid at cycle 3 with resp 2'b00, rdata 0, timeout 0.
REQ-018 Write with wready delayed 5 cycles after the AW handshake → awvalid low after the AW handshake; wvalid held with stable data until wready; exactly one response.
REQ-019 Read from 0x4, rvalid returns 0x1234_5678 with rresp 2'b00 after 3 cycles, rsp_ready low for 4 cycles → rsp fields held stable; next cmd_ready one cycle after rsp_ready.
REQ-020 Read with TIMEOUT = 8 and no rvalid → rsp_resp 2'b10, rsp_timeout 1, rsp_rdata 0; late rvalid accepted and discarded; cmd_ready low until then.
REQ-021 Rst pulsed while in WRESP → next cycle all outputs 0 and state IDLE; a subsequent read completes normally.
REQ-022 SLVERR bresp (2'b10) on write → rsp_resp 2'b10 with rsp_timeout 0.
